pipeline_ctrl: RTL and testbench

Central stall/flush sequencer and forwarding selector for the 5-stage RV32I core (IF, ID, EX, MEM, WB). It resolves data hazards (forwarding, load-use), control hazards (taken branch/jump in EX) and structural hazards (multi-cycle MUL/DIV in EX, instruction/data memory wait states). It drives the hold and clear controls of every pipeline register, and it keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/pipeline_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer and EX operand forwarding selector for a 5-stage RV32I pipeline.
// Resolves data, control and structural hazards and counts front-end stall cycles.
module pipeline_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int MC_LATENCY  = 4,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   i_aclk,
  input  logic                   i_areset,
  input  logic [REG_ADDR_W-1:0]  i_id_rs1,
  input  logic [REG_ADDR_W-1:0]  i_id_rs2,
  input  logic                   i_id_use_rs1,
  input  logic                   i_id_use_rs2,
  input  logic [REG_ADDR_W-1:0]  i_ex_rs1,
  input  logic [REG_ADDR_W-1:0]  i_ex_rs2,
  input  logic [REG_ADDR_W-1:0]  i_ex_rd,
  input  logic                   i_ex_is_load,
  input  logic                   i_ex_branch_taken,
  input  logic                   i_ex_mc_start,
  input  logic [REG_ADDR_W-1:0]  i_mem_rd,
  input  logic [REG_ADDR_W-1:0]  i_wb_rd,
  input  logic                   i_mem_we,
  input  logic                   i_wb_we,
  input  logic                   i_mem_req,
  input  logic                   i_dmem_ready,
  input  logic                   i_imem_ready,
  input  logic                   i_cnt_clr,
  output logic                   o_stall_if,
  output logic                   o_stall_id,
  output logic                   o_stall_ex,
  output logic                   o_stall_mem,
  output logic                   o_flush_id,
  output logic                   o_flush_ex,
  output logic                   o_flush_mem,
  output logic                   o_flush_wb,
  output logic [1:0]             o_fwd_a,
  output logic [1:0]             o_fwd_b,
  output logic                   o_mc_busy,
  output logic [STALL_CNT_W-1:0] o_stall_cnt
);

  // Wide enough for MC_LATENCY-2 at the top of the legal 2..16 range.
  localparam int MC_CNT_W = 4;

  typedef enum logic {
    RUN     = 1'b0,
    MC_BUSY = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_DMEM,
    ACT_MC,
    ACT_BRANCH,
    ACT_LOAD_USE,
    ACT_IFETCH
  } action_e;

  state_e                 state_q, state_d;
  logic [MC_CNT_W-1:0]    mc_cnt_q, mc_cnt_d;
  logic                   started_q, started_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  action_e action;
  logic    dmem_wait;
  logic    load_use;
  logic    mc_trigger;
  logic    mc_stall;
  logic    stall_if_raw, stall_id_raw, stall_ex_raw, stall_mem_raw;
  logic    flush_id_raw, flush_ex_raw, flush_mem_raw, flush_wb_raw;

  // MEM result is younger than WB, so it wins; x0 is hardwired and never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs);
    if (i_mem_we && (i_mem_rd != '0) && (i_mem_rd == rs))
      return 2'b01;
    else if (i_wb_we && (i_wb_rd != '0) && (i_wb_rd == rs))
      return 2'b10;
    else
      return 2'b00;
  endfunction

  assign dmem_wait = i_mem_req & ~i_dmem_ready;

  assign load_use = i_ex_is_load & (i_ex_rd != '0) &
                    ((i_id_use_rs1 & (i_id_rs1 == i_ex_rd)) |
                     (i_id_use_rs2 & (i_id_rs2 == i_ex_rd)));

  // The started flag keeps a still-asserted start from re-launching the op that just finished.
  assign mc_trigger = (state_q == RUN) & i_ex_mc_start & ~started_q;
  assign mc_stall   = mc_trigger | (state_q == MC_BUSY);

  always_comb begin
    if (dmem_wait)              action = ACT_DMEM;
    else if (mc_stall)          action = ACT_MC;
    else if (i_ex_branch_taken) action = ACT_BRANCH;
    else if (load_use)          action = ACT_LOAD_USE;
    else if (!i_imem_ready)     action = ACT_IFETCH;
    else                        action = ACT_NONE;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    stall_if_raw  = 1'b0;
    stall_id_raw  = 1'b0;
    stall_ex_raw  = 1'b0;
    stall_mem_raw = 1'b0;
    flush_id_raw  = 1'b0;
    flush_ex_raw  = 1'b0;
    flush_mem_raw = 1'b0;
    flush_wb_raw  = 1'b0;
    unique case (action)
      ACT_DMEM: begin
        stall_if_raw  = 1'b1;
        stall_id_raw  = 1'b1;
        stall_ex_raw  = 1'b1;
        stall_mem_raw = 1'b1;
        flush_wb_raw  = 1'b1;
      end
      ACT_MC: begin
        stall_if_raw  = 1'b1;
        stall_id_raw  = 1'b1;
        stall_ex_raw  = 1'b1;
        flush_mem_raw = 1'b1;
      end
      ACT_BRANCH: begin
        flush_id_raw = 1'b1;
        flush_ex_raw = 1'b1;
      end
      ACT_LOAD_USE: begin
        stall_if_raw = 1'b1;
        stall_id_raw = 1'b1;
        flush_ex_raw = 1'b1;
      end
      ACT_IFETCH: begin
        stall_if_raw = 1'b1;
        flush_id_raw = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mc_cnt_d    = mc_cnt_q;
    started_d   = started_q & i_ex_mc_start & stall_ex_raw;
    stall_cnt_d = stall_cnt_q;

    unique case (state_q)
      RUN: begin
        if (mc_trigger && !dmem_wait) begin
          started_d = 1'b1;
          // A two-cycle op is covered entirely by the launch cycle's stall.
          if (MC_LATENCY > 2) begin
            state_d  = MC_BUSY;
            mc_cnt_d = MC_CNT_W'(MC_LATENCY - 2);
          end
        end
      end
      MC_BUSY: begin
        // The MUL/DIV unit keeps running through memory wait states.
        mc_cnt_d = mc_cnt_q - MC_CNT_W'(1);
        if (mc_cnt_q == MC_CNT_W'(1))
          state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    if (i_cnt_clr)
      stall_cnt_d = '0;
    else if (stall_if_raw && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      state_q     <= RUN;
      mc_cnt_q    <= '0;
      started_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mc_cnt_q    <= mc_cnt_d;
      started_q   <= started_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Reset gates the controls immediately, independent of the clock.
  assign o_stall_if  = stall_if_raw  & ~i_areset;
  assign o_stall_id  = stall_id_raw  & ~i_areset;
  assign o_stall_ex  = stall_ex_raw  & ~i_areset;
  assign o_stall_mem = stall_mem_raw & ~i_areset;
  assign o_flush_id  = flush_id_raw  & ~i_areset;
  assign o_flush_ex  = flush_ex_raw  & ~i_areset;
  assign o_flush_mem = flush_mem_raw & ~i_areset;
  assign o_flush_wb  = flush_wb_raw  & ~i_areset;
  assign o_fwd_a     = i_areset ? 2'b00 : fwd_sel(i_ex_rs1);
  assign o_fwd_b     = i_areset ? 2'b00 : fwd_sel(i_ex_rs2);
  assign o_mc_busy   = (state_q == MC_BUSY);
  assign o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed literal checks plus a randomized run
// compared every cycle against a behavioural model of the hazard rules.
module tb_pipeline_ctrl;

  localparam int RW  = 5;
  localparam int LAT = 4;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic          id_use_rs1, id_use_rs2, ex_is_load, branch, mc_start;
  logic          mem_we, wb_we, mem_req, dmem_ready, imem_ready, cnt_clr;
  logic          stall_if, stall_id, stall_ex, stall_mem;
  logic          flush_id, flush_ex, flush_mem, flush_wb;
  logic [1:0]    fwd_a, fwd_b;
  logic          mc_busy;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .REG_ADDR_W (RW),
    .MC_LATENCY (LAT),
    .STALL_CNT_W(CW)
  ) dut (
    .i_aclk           (clk),
    .i_areset         (rst),
    .i_id_rs1         (id_rs1),
    .i_id_rs2         (id_rs2),
    .i_id_use_rs1     (id_use_rs1),
    .i_id_use_rs2     (id_use_rs2),
    .i_ex_rs1         (ex_rs1),
    .i_ex_rs2         (ex_rs2),
    .i_ex_rd          (ex_rd),
    .i_ex_is_load     (ex_is_load),
    .i_ex_branch_taken(branch),
    .i_ex_mc_start    (mc_start),
    .i_mem_rd         (mem_rd),
    .i_wb_rd          (wb_rd),
    .i_mem_we         (mem_we),
    .i_wb_we          (wb_we),
    .i_mem_req        (mem_req),
    .i_dmem_ready     (dmem_ready),
    .i_imem_ready     (imem_ready),
    .i_cnt_clr        (cnt_clr),
    .o_stall_if       (stall_if),
    .o_stall_id       (stall_id),
    .o_stall_ex       (stall_ex),
    .o_stall_mem      (stall_mem),
    .o_flush_id       (flush_id),
    .o_flush_ex       (flush_ex),
    .o_flush_mem      (flush_mem),
    .o_flush_wb       (flush_wb),
    .o_fwd_a          (fwd_a),
    .o_fwd_b          (fwd_b),
    .o_mc_busy        (mc_busy),
    .o_stall_cnt      (stall_cnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_mem, flush_wb}
  function automatic logic [7:0] ctrl_vec();
    return {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_mem, flush_wb};
  endfunction

  // ---------------- behavioural model ----------------
  int          m_busy_left;  // remaining cycles flagged busy for the op in EX
  bit          m_started;    // current EX op has already been launched
  int unsigned m_cnt;

  function automatic logic [1:0] m_fwd(input logic [RW-1:0] rs);
    if (rst) return 2'b00;
    if (mem_we && mem_rd != 0 && mem_rd == rs) return 2'b01;
    if (wb_we && wb_rd != 0 && wb_rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [7:0] m_ctrl();
    bit dw, lu, mcs;
    dw  = mem_req && !dmem_ready;
    lu  = ex_is_load && ex_rd != 0 &&
          ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    mcs = (m_busy_left > 0) || (mc_start && !m_started);
    if (rst)         return 8'b0000_0000;
    if (dw)          return 8'b1111_0001;
    if (mcs)         return 8'b1110_0010;
    if (branch)      return 8'b0000_1100;
    if (lu)          return 8'b1100_0100;
    if (!imem_ready) return 8'b1000_1000;
    return 8'b0000_0000;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy_left = 0;
      m_started   = 1'b0;
      m_cnt       = 0;
    end else begin
      logic [7:0] c;
      bit         launch, keep;
      c      = m_ctrl();
      launch = mc_start && !m_started && m_busy_left == 0 && !(mem_req && !dmem_ready);
      keep   = m_started && mc_start && c[5];
      if (m_busy_left > 0) m_busy_left = m_busy_left - 1;
      else if (launch)     m_busy_left = LAT - 2;
      m_started = launch || keep;
      if (cnt_clr)                       m_cnt = 0;
      else if (c[7] && m_cnt < (2**CW - 1)) m_cnt = m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    check("ctrl",    32'(ctrl_vec()), 32'(m_ctrl()));
    check("fwd_a",   32'(fwd_a),      32'(m_fwd(ex_rs1)));
    check("fwd_b",   32'(fwd_b),      32'(m_fwd(ex_rs2)));
    check("mc_busy", 32'(mc_busy),    32'(m_busy_left > 0));
    check("cnt",     32'(stall_cnt),  m_cnt);
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_is_load = 0; branch = 0; mc_start = 0;
    mem_rd = 0; wb_rd = 0; mem_we = 0; wb_we = 0; mem_req = 0;
    dmem_ready = 1; imem_ready = 1; cnt_clr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    branch = 1; mem_we = 1; mem_rd = 3; ex_rs1 = 3; imem_ready = 0;
    #2;
    check("reset_ctrl", 32'(ctrl_vec()), 32'h0);
    check("reset_fwd",  32'({fwd_a, fwd_b}), 32'h0);
    check("reset_busy", 32'(mc_busy), 32'h0);
    check("reset_cnt",  32'(stall_cnt), 32'h0);
    @(negedge clk);
    idle();
    rst = 1'b0;
    tick();

    // Forwarding priority and x0.
    ex_rs1 = 5; mem_rd = 5; mem_we = 1; wb_rd = 5; wb_we = 1; #2;
    check("fwd_mem_wins", 32'(fwd_a), 32'h1);
    mem_rd = 0; #2;
    check("fwd_wb", 32'(fwd_a), 32'h2);
    ex_rs2 = 5; #2;
    check("fwd_b_wb", 32'(fwd_b), 32'h2);
    ex_rs1 = 0; mem_rd = 0; wb_rd = 0; #2;
    check("fwd_x0", 32'(fwd_a), 32'h0);
    tick();

    // Load-use: lw x7 in EX, add x1,x7,x2 in ID.
    idle();
    ex_is_load = 1; ex_rd = 7;
    id_rs1 = 7; id_rs2 = 2; id_use_rs1 = 1; id_use_rs2 = 1; #2;
    check("load_use", 32'(ctrl_vec()), 32'hC4);
    tick();
    idle();
    mem_rd = 7; mem_we = 1; ex_rs1 = 7; ex_rs2 = 2; ex_rd = 1; #2;
    check("load_use_after_ctrl", 32'(ctrl_vec()), 32'h00);
    check("load_use_after_fwd",  32'(fwd_a), 32'h1);
    tick();
    idle();
    ex_is_load = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1; #2;
    check("load_x0_no_stall", 32'(ctrl_vec()), 32'h00);
    tick();

    // Multi-cycle op held for its whole occupancy.
    idle(); cnt_clr = 1; tick();
    cnt_clr = 0; mc_start = 1;
    for (int k = 1; k <= 4; k++) begin
      #2;
      check($sformatf("mc_ctrl_%0d", k), 32'(ctrl_vec()), (k <= 3) ? 32'hE2 : 32'h00);
      check($sformatf("mc_busy_%0d", k), 32'(mc_busy), 32'(k == 2 || k == 3));
      tick();
    end
    mc_start = 0; #2;
    check("mc_stall_cnt", 32'(stall_cnt), 32'd3);
    tick();

    // Branch beats load-use; data-memory wait beats both.
    idle();
    branch = 1; ex_is_load = 1; ex_rd = 3; id_rs1 = 3; id_use_rs1 = 1; #2;
    check("branch_vs_lu", 32'(ctrl_vec()), 32'h0C);
    mem_req = 1; dmem_ready = 0; #2;
    check("dmem_vs_branch", 32'(ctrl_vec()), 32'hF1);
    tick();

    // Data-memory wait on the final busy cycle and the cycle after.
    idle(); mc_start = 1; tick();
    tick();
    mem_req = 1; dmem_ready = 0; #2;
    check("mc_dmem_ctrl1", 32'(ctrl_vec()), 32'hF1);
    check("mc_dmem_busy1", 32'(mc_busy), 32'h1);
    tick(); #2;
    check("mc_dmem_ctrl2", 32'(ctrl_vec()), 32'hF1);
    check("mc_dmem_busy2", 32'(mc_busy), 32'h0);
    tick();
    mem_req = 0; #2;
    check("mc_dmem_done", 32'(ctrl_vec()), 32'h00);
    tick();

    // Asynchronous reset in the middle of MC_BUSY.
    idle(); tick();
    mc_start = 1; tick(); #2;
    check("pre_reset_busy", 32'(mc_busy), 32'h1);
    rst = 1'b1; #1;
    check("mid_reset_ctrl", 32'(ctrl_vec()), 32'h00);
    check("mid_reset_busy", 32'(mc_busy), 32'h0);
    @(negedge clk);
    idle();
    rst = 1'b0;
    tick();

    // Counter saturation and clear while stalling.
    imem_ready = 0;
    for (int k = 0; k < 18; k++) tick();
    #2;
    check("cnt_saturated", 32'(stall_cnt), 32'hF);
    cnt_clr = 1; tick();
    cnt_clr = 0; #2;
    check("cnt_cleared", 32'(stall_cnt), 32'h0);
    tick();

    // Randomized run against the model.
    for (int n = 0; n < 4000; n++) begin
      rst        = ($urandom_range(0, 499) == 0);
      id_rs1     = RW'($urandom_range(0, 3));
      id_rs2     = RW'($urandom_range(0, 3));
      id_use_rs1 = 1'($urandom);
      id_use_rs2 = 1'($urandom);
      ex_rs1     = RW'($urandom_range(0, 3));
      ex_rs2     = RW'($urandom_range(0, 3));
      ex_rd      = RW'($urandom_range(0, 3));
      mem_rd     = RW'($urandom_range(0, 3));
      wb_rd      = RW'($urandom_range(0, 3));
      ex_is_load = ($urandom_range(0, 3) == 0);
      branch     = ($urandom_range(0, 5) == 0);
      mem_we     = 1'($urandom);
      wb_we      = 1'($urandom);
      mem_req    = ($urandom_range(0, 3) == 0);
      dmem_ready = ($urandom_range(0, 2) != 0);
      imem_ready = ($urandom_range(0, 6) != 0);
      cnt_clr    = ($urandom_range(0, 99) == 0);
      if (mc_start) mc_start = ($urandom_range(0, 4) != 0);
      else          mc_start = ($urandom_range(0, 9) == 0);
      tick();
    end
    rst = 1'b0;
    idle();
    tick();
    @(negedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
